// File: rtl/modulo_varredura_coluna_pkg.sv
// Shared types and helpers for the LED-matrix column scanner.
// Holds drive-level functions, counter width helper and code constants.
package modulo_varredura_coluna_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_st_t;

   // col_code is the column index with this bit prepended as MSB
   localparam logic CODE_MSB = 1'b0;

   function automatic logic col_off(input bit active_low);
      return active_low ? 1'b1 : 1'b0;
   endfunction

   function automatic logic col_on(input bit active_low);
      return ~col_off(active_low);
   endfunction

   // width of a 0..m-1 counter, never narrower than 1 bit
   function automatic int cnt_w(input int m);
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/modulo_varredura_coluna_contador.sv
// Modulo-M counter with enable, terminal-count flag and sync reset.
// Ports: clk, reset, en in; cnt (0..M-1) and tc (cnt==M-1) out.
module contador_modulo
   import modulo_varredura_coluna_pkg::*;
#(
   parameter int M = 4,
   parameter int W = cnt_w(M)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   localparam logic [W-1:0] LAST = W'(M - 1);

   assign tc = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/modulo_varredura_coluna.sv
// Free-running LED-matrix column scanner with dwell, blink and match.
// Ports: clk, reset, enable, blink_en, coord_sel in; col_drive, col_idx,
// col_code, hit, frame_tick, sel_err out.
module modulo_varredura_coluna
   import modulo_varredura_coluna_pkg::*;
#(
   parameter int N_COLS       = 5,
   parameter int COORD_W      = 3,
   parameter int DWELL        = 50000,
   parameter int BLINK_FRAMES = 25,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               blink_en,
   input  logic [COORD_W-1:0] coord_sel,
   output logic [N_COLS-1:0]  col_drive,
   output logic [COORD_W-1:0] col_idx,
   output logic [COORD_W:0]   col_code,
   output logic               hit,
   output logic               frame_tick,
   output logic               sel_err
);

   localparam int DW = cnt_w(DWELL);
   localparam int FW = cnt_w(BLINK_FRAMES);
   localparam logic OFF = col_off(ACTIVE_LOW != 0);
   localparam logic ON  = col_on(ACTIVE_LOW != 0);
   localparam logic [COORD_W:0]   NCOLS_W  = (COORD_W + 1)'(N_COLS);
   localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(N_COLS - 1);

   scan_st_t st, nst;

   logic [DW-1:0]      dcnt;
   logic               dtc;
   logic [FW-1:0]      fcnt;
   logic               ftc;
   logic [COORD_W-1:0] idx;
   logic               blink_ph;
   logic               run;
   logic               wrap;
   logic               blank;
   logic               hit_d;
   logic               tick_d;
   logic [N_COLS-1:0]  drv_d;
   logic               unused_cnt;

   // counter values are only needed through their terminal flags
   assign unused_cnt = ^{dcnt, fcnt};

   assign sel_err = ({1'b0, coord_sel} >= NCOLS_W);
   assign col_code = {CODE_MSB, col_idx};

   contador_modulo #(
      .M (DWELL),
      .W (DW)
   ) u_dwell (
      .clk   (clk),
      .reset (reset),
      .en    (run),
      .cnt   (dcnt),
      .tc    (dtc)
   );

   contador_modulo #(
      .M (BLINK_FRAMES),
      .W (FW)
   ) u_frame (
      .clk   (clk),
      .reset (reset),
      .en    (run && wrap),
      .cnt   (fcnt),
      .tc    (ftc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         st <= IDLE;
      end else begin
         st <= nst;
      end
   end

   always_comb begin
      nst = st;
      unique case (st)
         IDLE: nst = enable ? SCAN : IDLE;
         SCAN: nst = enable ? SCAN : IDLE;
      endcase
   end

   // Output logic computes next-cycle values; the register below
   // makes every visible output change on the same edge.
   always_comb begin
      run    = (nst == SCAN);
      wrap   = dtc && (idx == LAST_COL);
      blank  = blink_en && blink_ph &&
               (idx == coord_sel) && !sel_err;
      hit_d  = run && (idx == coord_sel) && !sel_err;
      tick_d = run && wrap;
      drv_d  = {N_COLS{OFF}};
      if (run && !blank) begin
         for (int i = 0; i < N_COLS; i++) begin
            if (idx == COORD_W'(i)) begin
               drv_d[i] = ON;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx <= '0;
      end else if (run && dtc) begin
         idx <= (idx == LAST_COL) ? '0 : idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_ph <= 1'b0;
      end else if (run && wrap && ftc) begin
         blink_ph <= ~blink_ph;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_drive  <= {N_COLS{OFF}};
         col_idx    <= '0;
         hit        <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         col_drive  <= drv_d;
         col_idx    <= idx;
         hit        <= hit_d;
         frame_tick <= tick_d;
      end
   end

endmodule

// File: tb/tb_modulo_varredura_coluna.sv
// Directed vector bench for modulo_varredura_coluna.
// N_COLS=5, DWELL=4, BLINK_FRAMES=2, active-low drive.
module tb_modulo_varredura_coluna;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       blink_en;
   logic [2:0] coord_sel;
   logic [4:0] col_drive;
   logic [2:0] col_idx;
   logic [3:0] col_code;
   logic       hit;
   logic       frame_tick;
   logic       sel_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   modulo_varredura_coluna #(
      .N_COLS       (5),
      .COORD_W      (3),
      .DWELL        (4),
      .BLINK_FRAMES (2),
      .ACTIVE_LOW   (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .blink_en   (blink_en),
      .coord_sel  (coord_sel),
      .col_drive  (col_drive),
      .col_idx    (col_idx),
      .col_code   (col_code),
      .hit        (hit),
      .frame_tick (frame_tick),
      .sel_err    (sel_err)
   );

   typedef struct {
      logic       rst;
      logic       en;
      logic       blk;
      logic [2:0] sel;
      logic [4:0] drv;
      logic [2:0] idx;
      logic       hit;
      logic       tick;
      logic       err;
   } vec_t;

   vec_t vq[$];

   // expected outputs after the k-th clock edge since reset release
   function automatic vec_t mk(logic rst, logic en, logic blk,
                               logic [2:0] sel, int k);
      vec_t v;
      int col, f, ph;
      logic blank;
      logic [4:0] one;
      one = 5'b00001;
      v.rst = rst; v.en = en; v.blk = blk; v.sel = sel;
      v.err = (sel >= 3'd5);
      if (rst) begin
         v.drv = 5'b11111; v.idx = 3'd0;
         v.hit = 1'b0; v.tick = 1'b0;
      end else begin
         col = ((k - 1) / 4) % 5;
         f = (k - 1) / 20;
         ph = (f / 2) % 2;
         blank = blk && (ph == 1) && (col == int'(sel)) && !v.err;
         v.drv = blank ? 5'b11111 : ~(one << col);
         v.idx = 3'(col);
         v.hit = (col == int'(sel)) && !v.err;
         v.tick = (k % 20 == 0);
      end
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h",
                  nm, $time, act, exp);
      end
   endtask

   task automatic cmp(vec_t v);
      chk("col_drive", 32'(col_drive), 32'(v.drv));
      chk("col_idx", 32'(col_idx), 32'(v.idx));
      chk("col_code", 32'(col_code), 32'({1'b0, v.idx}));
      chk("hit", 32'(hit), 32'(v.hit));
      chk("frame_tick", 32'(frame_tick), 32'(v.tick));
      chk("sel_err", 32'(sel_err), 32'(v.err));
   endtask

   task automatic apply(vec_t v);
      reset = v.rst;
      enable = v.en;
      blink_en = v.blk;
      coord_sel = v.sel;
      @(posedge clk);
      #1;
      cmp(v);
   endtask

   initial begin
      vec_t p;
      reset = 1'b1; enable = 1'b0; blink_en = 1'b0; coord_sel = 3'd0;

      // basic scan with coord_sel=3
      vq.push_back(mk(1'b1, 1'b1, 1'b0, 3'd3, 0));
      vq.push_back(mk(1'b1, 1'b1, 1'b0, 3'd3, 0));
      for (int k = 1; k <= 40; k++)
         vq.push_back(mk(1'b0, 1'b1, 1'b0, 3'd3, k));
      // blink column 2 over frames 0..5
      vq.push_back(mk(1'b1, 1'b1, 1'b1, 3'd2, 0));
      for (int k = 1; k <= 120; k++)
         vq.push_back(mk(1'b0, 1'b1, 1'b1, 3'd2, k));
      // out-of-range selection: no hit, no blanking
      vq.push_back(mk(1'b1, 1'b1, 1'b1, 3'd6, 0));
      for (int k = 1; k <= 100; k++)
         vq.push_back(mk(1'b0, 1'b1, 1'b1, 3'd6, k));

      for (int i = 0; i < vq.size(); i++)
         apply(vq[i]);

      // pause mid-column 2 for 7 cycles, then resume
      apply(mk(1'b1, 1'b1, 1'b0, 3'd2, 0));
      for (int k = 1; k <= 10; k++)
         apply(mk(1'b0, 1'b1, 1'b0, 3'd2, k));
      p = mk(1'b0, 1'b0, 1'b0, 3'd2, 10);
      p.drv = 5'b11111; p.idx = 3'd2;
      p.hit = 1'b0; p.tick = 1'b0;
      for (int j = 0; j < 7; j++)
         apply(p);
      for (int k = 11; k <= 20; k++)
         apply(mk(1'b0, 1'b1, 1'b0, 3'd2, k));

      // reset while column 4 is active and enable is high
      apply(mk(1'b1, 1'b1, 1'b0, 3'd4, 0));
      for (int k = 1; k <= 17; k++)
         apply(mk(1'b0, 1'b1, 1'b0, 3'd4, k));
      apply(mk(1'b1, 1'b1, 1'b0, 3'd4, 0));
      for (int k = 1; k <= 8; k++)
         apply(mk(1'b0, 1'b1, 1'b0, 3'd4, k));

      // sel_err follows coord_sel without a clock edge
      coord_sel = 3'd7; #1;
      chk("sel_err_comb7", 32'(sel_err), 32'd1);
      coord_sel = 3'd4; #1;
      chk("sel_err_comb4", 32'(sel_err), 32'd0);
      coord_sel = 3'd5; #1;
      chk("sel_err_comb5", 32'(sel_err), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
